// File: rtl/render_pkg.sv
// Shared definitions for the pixel render engine: op codes, op enum and FSM states.
package render_pkg;

  localparam logic [2:0] OPC_CLEAR     = 3'd0;
  localparam logic [2:0] OPC_NOOP      = 3'd1;
  localparam logic [2:0] OPC_FILL_RECT = 3'd5;
  localparam logic [2:0] OPC_DRAW_LINE = 3'd6;

  typedef enum logic [2:0] {
    OP_CLEAR     = OPC_CLEAR,
    OP_NOOP      = OPC_NOOP,
    OP_FILL_RECT = OPC_FILL_RECT,
    OP_DRAW_LINE = OPC_DRAW_LINE
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FILL  = 3'd3,
    ST_LINE  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/line_stepper.sv
// Integer Bresenham walker for all octants: load the endpoints, then each step advances one pixel.
module line_stepper #(
  parameter int XBITS = 9,
  parameter int YBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [XBITS-1:0] x0_i,
  input  logic [YBITS-1:0] y0_i,
  input  logic [XBITS-1:0] x1_i,
  input  logic [YBITS-1:0] y1_i,
  output logic [XBITS-1:0] x_o,
  output logic [YBITS-1:0] y_o,
  output logic             last_o
);

  localparam int EW = ((XBITS > YBITS) ? XBITS : YBITS) + 2;

  logic [XBITS-1:0]     x_q, x_d, x1_q;
  logic [YBITS-1:0]     y_q, y_d, y1_q;
  logic signed [EW-1:0] err_q, err_d, dx_q, dy_q, dx_c, dy_c;
  logic                 xneg_q, yneg_q;
  logic [XBITS-1:0]     adx;
  logic [YBITS-1:0]     ady;
  logic signed [EW:0]   e2, dxw, dyw;

  assign adx  = (x1_i >= x0_i) ? x1_i - x0_i : x0_i - x1_i;
  assign ady  = (y1_i >= y0_i) ? y1_i - y0_i : y0_i - y1_i;
  assign dx_c = $signed({{(EW-XBITS){1'b0}}, adx});
  // dy is kept negative so a single error term covers every octant.
  assign dy_c = -$signed({{(EW-YBITS){1'b0}}, ady});

  // 2*err needs one extra bit so the comparisons never wrap.
  assign e2  = {err_q, 1'b0};
  assign dxw = {dx_q[EW-1], dx_q};
  assign dyw = {dy_q[EW-1], dy_q};

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    err_d = err_q;
    if (load_i) begin
      x_d   = x0_i;
      y_d   = y0_i;
      err_d = dx_c + dy_c;
    end else if (step_i && !last_o) begin
      if (e2 >= dyw) begin
        err_d = err_d + dy_q;
        x_d   = xneg_q ? x_q - XBITS'(1) : x_q + XBITS'(1);
      end
      if (e2 <= dxw) begin
        err_d = err_d + dx_q;
        y_d   = yneg_q ? y_q - YBITS'(1) : y_q + YBITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      err_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      xneg_q <= 1'b0;
      yneg_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= err_d;
      if (load_i) begin
        x1_q   <= x1_i;
        y1_q   <= y1_i;
        dx_q   <= dx_c;
        dy_q   <= dy_c;
        xneg_q <= (x1_i < x0_i);
        yneg_q <= (y1_i < y0_i);
      end
    end
  end

endmodule

// File: rtl/render_core.sv
// Command-driven pixel generator: CLEAR, FILL_RECT and DRAW_LINE streamed over an enable/pixel_ready handshake.
// Handshake: a pixel moves on a rising edge where enable=1 and pixel_ready=1; while enable=1 and
// pixel_ready=0 the pixel (x, y, pixel_color) is held unchanged until it is accepted.
module render_core
  import render_pkg::*;
#(
  parameter int XWIDTH = 320,
  parameter int YWIDTH = 240,
  parameter int XBITS  = 9,
  parameter int YBITS  = 8,
  parameter int CBITS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [XBITS+YBITS-1:0] start_l,
  input  logic [XBITS+YBITS-1:0] end_l,
  input  logic [2:0]             op,
  input  logic [CBITS-1:0]       color,
  input  logic                   render_enable,
  input  logic                   pixel_ready,
  output logic [XBITS-1:0]       x,
  output logic [YBITS-1:0]       y,
  output logic [CBITS-1:0]       pixel_color,
  output logic                   enable,
  output logic                   render_done,
  output logic                   busy,
  output state_e                 dbg_state_o
);

  localparam logic [XBITS-1:0] XLAST = XBITS'(XWIDTH - 1);
  localparam logic [YBITS-1:0] YLAST = YBITS'(YWIDTH - 1);

  state_e           state_q, state_d;
  logic [XBITS-1:0] p0x_q, p1x_q, sx_q, sx_d, xlo_q, xhi_q, xlo_c, xhi_c, in0x, in1x, line_x;
  logic [YBITS-1:0] p0y_q, p1y_q, sy_q, sy_d, ylo_q, yhi_q, ylo_c, yhi_c, in0y, in1y, line_y;
  logic [2:0]       op_q;
  logic [CBITS-1:0] col_q;
  logic             xfer, scan_last, line_last;

  assign in0x = start_l[XBITS+YBITS-1:YBITS];
  assign in0y = start_l[YBITS-1:0];
  assign in1x = end_l[XBITS+YBITS-1:YBITS];
  assign in1y = end_l[YBITS-1:0];

  // Scan bounds: whole frame for CLEAR, normalised corners for FILL.
  assign xlo_c = (op_q == OPC_CLEAR) ? '0    : ((p0x_q < p1x_q) ? p0x_q : p1x_q);
  assign xhi_c = (op_q == OPC_CLEAR) ? XLAST : ((p0x_q < p1x_q) ? p1x_q : p0x_q);
  assign ylo_c = (op_q == OPC_CLEAR) ? '0    : ((p0y_q < p1y_q) ? p0y_q : p1y_q);
  assign yhi_c = (op_q == OPC_CLEAR) ? YLAST : ((p0y_q < p1y_q) ? p1y_q : p0y_q);

  assign enable      = (state_q == ST_CLEAR) || (state_q == ST_FILL) || (state_q == ST_LINE);
  assign busy        = enable || (state_q == ST_SETUP);
  assign render_done = (state_q == ST_DONE);
  assign dbg_state_o = state_q;
  assign xfer        = enable && pixel_ready;
  assign scan_last   = (sx_q == xhi_q) && (sy_q == yhi_q);

  assign x           = (state_q == ST_LINE) ? line_x : sx_q;
  assign y           = (state_q == ST_LINE) ? line_y : sy_q;
  assign pixel_color = ((state_q == ST_FILL) || (state_q == ST_LINE)) ? col_q : '0;

  line_stepper #(.XBITS(XBITS), .YBITS(YBITS)) u_line (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == ST_SETUP),
    .step_i ((state_q == ST_LINE) && pixel_ready),
    .x0_i   (p0x_q),
    .y0_i   (p0y_q),
    .x1_i   (p1x_q),
    .y1_i   (p1y_q),
    .x_o    (line_x),
    .y_o    (line_y),
    .last_o (line_last)
  );

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      ST_IDLE:  if (render_enable) state_d = ST_SETUP;
      ST_SETUP: begin
        sx_d = xlo_c;
        sy_d = ylo_c;
        if (!render_enable) state_d = ST_IDLE;
        else begin
          case (op_q)
            OPC_CLEAR:     state_d = ST_CLEAR;
            OPC_FILL_RECT: state_d = ST_FILL;
            OPC_DRAW_LINE: state_d = ST_LINE;
            default:       state_d = ST_DONE;
          endcase
        end
      end
      ST_CLEAR, ST_FILL: begin
        if (!render_enable) state_d = ST_IDLE;
        else if (xfer) begin
          if (scan_last) state_d = ST_DONE;
          else if (sx_q == xhi_q) begin
            sx_d = xlo_q;
            sy_d = sy_q + YBITS'(1);
          end else sx_d = sx_q + XBITS'(1);
        end
      end
      ST_LINE: begin
        if (!render_enable) state_d = ST_IDLE;
        else if (xfer && line_last) state_d = ST_DONE;
      end
      ST_DONE:  if (!render_enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      p0x_q   <= '0;
      p0y_q   <= '0;
      p1x_q   <= '0;
      p1y_q   <= '0;
      op_q    <= OPC_NOOP;
      col_q   <= '0;
      xlo_q   <= '0;
      xhi_q   <= '0;
      ylo_q   <= '0;
      yhi_q   <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      if ((state_q == ST_IDLE) && render_enable) begin
        p0x_q <= (in0x > XLAST) ? XLAST : in0x;
        p0y_q <= (in0y > YLAST) ? YLAST : in0y;
        p1x_q <= (in1x > XLAST) ? XLAST : in1x;
        p1y_q <= (in1y > YLAST) ? YLAST : in1y;
        op_q  <= op;
        col_q <= color;
      end
      if (state_q == ST_SETUP) begin
        xlo_q <= xlo_c;
        xhi_q <= xhi_c;
        ylo_q <= ylo_c;
        yhi_q <= yhi_c;
      end
    end
  end

endmodule

// File: tb/tb_render_core.sv
// Directed bench for render_core: scoreboard of expected {x,y,colour} pixels per command.
module tb_render_core;
  import render_pkg::*;

  localparam int XBITS = 9;
  localparam int YBITS = 8;
  localparam int CBITS = 1;
  localparam int PW    = XBITS + YBITS + CBITS;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [XBITS+YBITS-1:0] start_l, end_l;
  logic [2:0]             op;
  logic [CBITS-1:0]       color;
  logic                   render_enable, pixel_ready;
  logic [XBITS-1:0]       x;
  logic [YBITS-1:0]       y;
  logic [CBITS-1:0]       pixel_color;
  logic                   enable, render_done, busy;
  state_e                 dbg_state;

  render_core dut (
    .clk           (clk),
    .rst           (rst),
    .start_l       (start_l),
    .end_l         (end_l),
    .op            (op),
    .color         (color),
    .render_enable (render_enable),
    .pixel_ready   (pixel_ready),
    .x             (x),
    .y             (y),
    .pixel_color   (pixel_color),
    .enable        (enable),
    .render_done   (render_done),
    .busy          (busy),
    .dbg_state_o   (dbg_state)
  );

  // scoreboard
  logic [PW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_px(input int px, input int py, input logic [CBITS-1:0] c);
    logic [31:0] vx, vy;
    vx = px;
    vy = py;
    exp_q.push_back({vx[XBITS-1:0], vy[YBITS-1:0], c});
  endtask

  task automatic push_rect(input int xa, input int ya, input int xb, input int yb, input logic [CBITS-1:0] c);
    for (int j = ya; j <= yb; j++)
      for (int i = xa; i <= xb; i++) push_px(i, j, c);
  endtask

  // Reference Bresenham (textbook form, all octants, both endpoints).
  task automatic push_line(input int x0, input int y0, input int x1, input int y1, input logic [CBITS-1:0] c);
    int cx, cy, dx, dy, sx, sy, err, e2;
    cx = x0; cy = y0;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    for (int n = 0; n < 2000; n++) begin
      push_px(cx, cy, c);
      if (cx == x1 && cy == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  // driver: issue one command, consume pixels, check timing and the DONE hold/release.
  task automatic run_cmd(input string tag, input int x0, input int y0, input int x1, input int y1,
                         input logic [2:0] opc, input logic [CBITS-1:0] col, input bit toggle,
                         input bit ymono, input int exp_count, input int budget);
    int cyc, npix, bad, unstable, ybad, done_cyc, last_cyc, first_en, hold_bad, prev_y;
    bit stall;
    logic [PW-1:0] held, e;
    logic [31:0] vx0, vy0, vx1, vy1;
    cyc = 0; npix = 0; bad = 0; unstable = 0; ybad = 0; done_cyc = -1; last_cyc = -1;
    first_en = -1; hold_bad = 0; prev_y = -1; stall = 1'b0; held = '0;
    vx0 = x0; vy0 = y0; vx1 = x1; vy1 = y1;
    start_l = {vx0[XBITS-1:0], vy0[YBITS-1:0]};
    end_l   = {vx1[XBITS-1:0], vy1[YBITS-1:0]};
    op = opc;
    color = col;
    pixel_ready = 1'b0;
    render_enable = 1'b1;
    while (done_cyc < 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (stall && ({x, y, pixel_color} !== held)) unstable++;
      stall = 1'b0;
      if (enable && first_en < 0) first_en = cyc;
      if (render_done) done_cyc = cyc;
      else begin
        pixel_ready = toggle ? ~pixel_ready : 1'b1;
        if (enable && pixel_ready) begin
          npix++;
          last_cyc = cyc;
          if (exp_q.size() == 0) bad++;
          else begin
            e = exp_q.pop_front();
            if ({x, y, pixel_color} !== e) bad++;
          end
          if (ymono && npix > 1 && int'(y) != prev_y + 1) ybad++;
          prev_y = int'(y);
        end else if (enable) begin
          stall = 1'b1;
          held = {x, y, pixel_color};
        end
      end
    end
    chk({tag, " done_seen"}, 32'(done_cyc > 0), 1);
    chk({tag, " pixel_count"}, npix, exp_count);
    chk({tag, " pixel_mismatches"}, bad, 0);
    chk({tag, " leftover_expected"}, exp_q.size(), 0);
    chk({tag, " stall_unstable"}, unstable, 0);
    chk({tag, " y_step_errors"}, ybad, 0);
    if (exp_count > 0) begin
      chk({tag, " first_enable_cycle"}, first_en, 2);
      chk({tag, " done_after_last"}, done_cyc - last_cyc, 1);
    end else begin
      chk({tag, " done_cycle"}, done_cyc, 2);
      chk({tag, " enable_never"}, first_en, -1);
    end
    exp_q.delete();
    pixel_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (!(render_done && !enable && dbg_state == ST_DONE)) hold_bad++;
    end
    chk({tag, " done_hold"}, hold_bad, 0);
    render_enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle_after_release"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, " done_cleared"}, 32'(render_done), 0);
  endtask

  int bad_cnt;

  initial begin
    rst = 1'b1;
    start_l = '0; end_l = '0; op = 3'd1; color = '0;
    render_enable = 1'b0; pixel_ready = 1'b0;
    #1;
    chk("reset enable", 32'(enable), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset render_done", 32'(render_done), 0);
    chk("reset xy", {x, y}, 0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Undefined op behaves as NOOP.
    run_cmd("op3", 5, 5, 9, 9, 3'd3, 1'b1, 1'b0, 1'b0, 0, 20);

    push_px(159, 40, 1'b1);
    run_cmd("line_point", 159, 40, 159, 40, OPC_DRAW_LINE, 1'b1, 1'b0, 1'b0, 1, 20);

    push_line(20, 40, 81, 189, 1'b1);
    run_cmd("line_steep", 20, 40, 81, 189, OPC_DRAW_LINE, 1'b1, 1'b0, 1'b1, 150, 400);

    push_rect(10, 10, 12, 12, 1'b1);
    run_cmd("fill_swapped", 12, 12, 10, 10, OPC_FILL_RECT, 1'b1, 1'b0, 1'b0, 9, 50);

    push_rect(317, 237, 319, 239, 1'b1);
    run_cmd("fill_clamp", 400, 250, 317, 237, OPC_FILL_RECT, 1'b1, 1'b0, 1'b0, 9, 50);

    push_line(0, 239, 319, 0, 1'b1);
    run_cmd("line_diag_stall", 0, 239, 319, 0, OPC_DRAW_LINE, 1'b1, 1'b1, 1'b0, 320, 1000);

    // Abort CLEAR by dropping render_enable.
    start_l = '0; end_l = '0; op = OPC_CLEAR; color = 1'b1;
    pixel_ready = 1'b1; render_enable = 1'b1;
    repeat (20) @(posedge clk);
    #1 render_enable = 1'b0;
    @(posedge clk); #1;
    chk("abort state", 32'(dbg_state), 32'(ST_IDLE));
    chk("abort enable", 32'(enable), 0);
    chk("abort busy", 32'(busy), 0);
    bad_cnt = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (render_done || enable) bad_cnt++;
    end
    chk("abort quiet", bad_cnt, 0);

    run_cmd_clear();

    // Reset in the middle of a line.
    start_l = {9'd0, 8'd0}; end_l = {9'd200, 8'd100}; op = OPC_DRAW_LINE; color = 1'b1;
    pixel_ready = 1'b1; render_enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midline active", 32'(enable), 1);
    rst = 1'b1;
    #1;
    chk("midline rst enable", 32'(enable), 0);
    chk("midline rst done", 32'(render_done), 0);
    chk("midline rst busy", 32'(busy), 0);
    chk("midline rst xy", {x, y}, 0);
    chk("midline rst state", 32'(dbg_state), 32'(ST_IDLE));
    render_enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    bad_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (enable || busy) bad_cnt++;
    end
    chk("post reset quiet", bad_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic run_cmd_clear();
    for (int j = 0; j < 240; j++)
      for (int i = 0; i < 320; i++) push_px(i, j, 1'b0);
    run_cmd("clear", 3, 3, 7, 7, OPC_CLEAR, 1'b1, 1'b0, 1'b0, 76800, 77000);
  endtask

endmodule
